icmp_echo_responder: RTL and testbench

Receive-side ICMP responder that complements the ICMP message builder/reader. It accepts an ICMP message as a stream of 32-bit words, verifies the Internet (ones'-complement) checksum, and reports the received type and code. Valid Echo Requests (type 8, code 0) are answered with an Echo Reply (type 0) that carries the same rest-of-header and data and a recomputed checksum. The reply is sent on a valid/ready output stream.

---
 rtl/icmp_pkg.sv | 25 ++
 rtl/icmp_csum_acc.sv | 33 +++
 rtl/icmp_echo_responder.sv | 173 +++++++++++++++++
 tb/tb_icmp_echo_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icmp_pkg.sv
// Shared ICMP definitions: message type codes, responder state encoding and
// the ones'-complement adder used by both the builder and the responder.
package icmp_pkg;

  localparam logic [7:0] ICMP_ECHO_REQUEST = 8'd8;
  localparam logic [7:0] ICMP_ECHO_REPLY   = 8'd0;

  localparam int MAX_WORDS = 16;
  localparam int IDXW      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_SEND
  } icmp_state_e;

  // a + b never exceeds 17'h1FFFE, so a single end-around fold cannot overflow.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/icmp_csum_acc.sv
// 16-bit ones'-complement accumulator: adds both halves of a 32-bit word per
// enabled cycle with end-around carry. Synchronous clear has priority.
module icmp_csum_acc
  import icmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [31:0] i_word,
  output logic [15:0] o_sum
);

  logic [15:0] r_sum;
  logic [15:0] w_sum_next;

  assign w_sum_next = ones_add(ones_add(r_sum, i_word[31:16]), i_word[15:0]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= 16'h0000;
    end else if (i_clr) begin
      r_sum <= 16'h0000;
    end else if (i_en) begin
      r_sum <= w_sum_next;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/icmp_echo_responder.sv
// ICMP receive path: checks the Internet checksum and answers Echo Requests.
// Optional macro ICMP_ECHO_CSUM_CHECK_EN enables checksum verification.
module icmp_echo_responder
  import icmp_pkg::*;
#(
  parameter int NWORDS = 5
) (
  input  logic        clock,
  input  logic        hardreset_n,
  input  logic [31:0] inputdata,
  input  logic        inputvalid,
  output logic [31:0] outputmessage,
  output logic        outputvalid,
  input  logic        outputready,
  output logic [7:0]  typeoficmpout,
  output logic [7:0]  codeout,
  output logic        rxdone,
  output logic        checksumerr,
  output logic        busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  icmp_state_e     r_state;
  icmp_state_e     w_next;
  logic [IDXW-1:0] r_count;
  logic [IDXW-1:0] r_idx;
  logic [31:0]     r_buf [MAX_WORDS];
  logic [7:0]      r_rx_type;
  logic [7:0]      r_rx_code;
  logic [15:0]     r_reply_csum;
  logic [7:0]      r_type_out;
  logic [7:0]      r_code_out;
  logic            r_rxdone;

  logic [15:0]     w_sum;
  logic            w_first_fire;
  logic            w_recv_fire;
  logic            w_pass;
  logic            w_is_echo;
  logic [15:0]     w_reply_csum;

  assign w_first_fire = (r_state == ST_IDLE) && inputvalid;
  assign w_recv_fire  = (r_state == ST_RECV) && inputvalid;
  assign w_is_echo    = (r_rx_type == ICMP_ECHO_REQUEST) && (r_rx_code == 8'h00);
  assign w_reply_csum = ~ones_add(w_sum, {8'h00, r_rx_code});

  icmp_csum_acc u_acc (
    .clk    (clock),
    .rst_n  (hardreset_n),
    .i_clr  (w_first_fire),
    .i_en   (w_recv_fire),
    .i_word (inputdata),
    .o_sum  (w_sum)
  );

`ifdef ICMP_ECHO_CSUM_CHECK_EN
  logic [15:0] r_rx_csum;
  logic        r_csumerr;
  logic [15:0] w_verify;

  // A correct message sums to negative zero over every 16-bit field.
  assign w_verify = ones_add(ones_add(w_sum, {r_rx_type, r_rx_code}), r_rx_csum);
  assign w_pass   = (w_verify == 16'hFFFF);

  always_ff @(posedge clock or negedge hardreset_n) begin
    if (!hardreset_n) begin
      r_rx_csum <= 16'h0000;
      r_csumerr <= 1'b0;
    end else begin
      r_csumerr <= (r_state == ST_CHECK) && !w_pass;
      if (w_first_fire) begin
        r_rx_csum <= inputdata[15:0];
      end
    end
  end

  assign checksumerr = r_csumerr;
`else
  assign w_pass      = 1'b1;
  assign checksumerr = 1'b0;
`endif

  always_ff @(posedge clock or negedge hardreset_n) begin
    if (!hardreset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (inputvalid) w_next = (LAST_IDX == '0) ? ST_CHECK : ST_RECV;
      ST_RECV:  if (inputvalid && (r_count == LAST_IDX)) w_next = ST_CHECK;
      ST_CHECK: w_next = (w_pass && w_is_echo) ? ST_SEND : ST_IDLE;
      ST_SEND:  if (outputready && (r_idx == LAST_IDX)) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge hardreset_n) begin
    if (!hardreset_n) begin
      r_count      <= '0;
      r_idx        <= '0;
      r_rx_type    <= 8'h00;
      r_rx_code    <= 8'h00;
      r_reply_csum <= 16'h0000;
      r_type_out   <= 8'h00;
      r_code_out   <= 8'h00;
      r_rxdone     <= 1'b0;
    end else begin
      r_rxdone <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (inputvalid) begin
            r_rx_type <= inputdata[31:24];
            r_rx_code <= inputdata[23:16];
            r_count   <= IDXW'(1);
          end
        end
        ST_RECV: begin
          if (inputvalid) begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_CHECK: begin
          r_count <= '0;
          r_idx   <= '0;
          if (w_pass) begin
            r_rxdone     <= 1'b1;
            r_type_out   <= r_rx_type;
            r_code_out   <= r_rx_code;
            r_reply_csum <= w_reply_csum;
          end
        end
        ST_SEND: begin
          if (outputready) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the payload buffer is deliberately not reset; it is always written
  // before it is read, and outputmessage is gated to zero outside SEND.
  always_ff @(posedge clock) begin
    if (w_recv_fire) begin
      r_buf[r_count] <= inputdata;
    end
  end

  assign outputvalid = (r_state == ST_SEND);
  assign busy        = (r_state == ST_CHECK) || (r_state == ST_SEND);

  always_comb begin
    outputmessage = 32'h0000_0000;
    if (outputvalid) begin
      outputmessage = (r_idx == '0) ? {ICMP_ECHO_REPLY, r_rx_code, r_reply_csum}
                                    : r_buf[r_idx];
    end
  end

  assign typeoficmpout = r_type_out;
  assign codeout       = r_code_out;
  assign rxdone        = r_rxdone;

endmodule

// File: tb/tb_icmp_echo_responder.sv
// Scoreboard bench for icmp_echo_responder: expected reply words are queued by
// the stimulus and consumed by an independent output monitor.
module tb_icmp_echo_responder;

  localparam int NW = 5;

  logic        clock;
  logic        hardreset_n;
  logic [31:0] inputdata;
  logic        inputvalid;
  logic [31:0] outputmessage;
  logic        outputvalid;
  logic        outputready;
  logic [7:0]  typeoficmpout;
  logic [7:0]  codeout;
  logic        rxdone;
  logic        checksumerr;
  logic        busy;

  icmp_echo_responder #(.NWORDS(NW)) dut (
    .clock         (clock),
    .hardreset_n   (hardreset_n),
    .inputdata     (inputdata),
    .inputvalid    (inputvalid),
    .outputmessage (outputmessage),
    .outputvalid   (outputvalid),
    .outputready   (outputready),
    .typeoficmpout (typeoficmpout),
    .codeout       (codeout),
    .rxdone        (rxdone),
    .checksumerr   (checksumerr),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt_rx = 0;
  int cnt_err = 0;
  int cnt_out = 0;
  logic [31:0] exp_q [$];

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pulse counters and in-order reply comparison on each handshake.
  always @(negedge clock) begin
    if (rxdone) cnt_rx++;
    if (checksumerr) cnt_err++;
    if (outputvalid && outputready) begin
      cnt_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_reply_word: got %08h expected none", outputmessage);
      end else begin
        check("reply_word", outputmessage, exp_q.pop_front());
      end
    end
  end

  task automatic push5(input logic [31:0] a, b, c, d, e);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    exp_q.push_back(e);
  endtask

  // Called at 1ns after a rising edge; returns at 1ns after edge E (CHECK cycle).
  task automatic send_msg(input logic [31:0] w0, w1, w2, w3, w4,
                          input int gap_after, input int gap_len);
    logic [31:0] w [NW];
    w = '{w0, w1, w2, w3, w4};
    for (int i = 0; i < NW; i++) begin
      inputdata  = w[i];
      inputvalid = 1'b1;
      @(posedge clock);
      #1;
      inputvalid = 1'b0;
      if (i == gap_after) begin
        repeat (gap_len) begin
          @(posedge clock);
          #1;
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(name, 32'(n < 100), 32'd1);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  int rx0, err0, out0, t0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hardreset_n = 1'b0;
    inputdata   = 32'h0;
    inputvalid  = 1'b0;
    outputready = 1'b1;
    #2;
    check("rst_outputvalid", {31'd0, outputvalid}, 32'd0);
    check("rst_outputmessage", outputmessage, 32'h0);
    check("rst_type", {24'd0, typeoficmpout}, 32'h0);
    check("rst_code", {24'd0, codeout}, 32'h0);
    check("rst_flags", {29'd0, rxdone, checksumerr, busy}, 32'd0);
    #10 hardreset_n = 1'b1;
    step();
    check("post_rst_idle", {30'd0, busy, outputvalid}, 32'd0);

    // Valid echo request.
    rx0 = cnt_rx; out0 = cnt_out;
    push5(32'h0000FFFC, 32'h00010002, 32'h0, 32'h0, 32'h0);
    send_msg(32'h0800F7FC, 32'h00010002, 32'h0, 32'h0, 32'h0, -1, 0);
    check("echo_busy_in_check", {31'd0, busy}, 32'd1);
    step();
    t0 = cyc;
    check("echo_rxdone", {31'd0, rxdone}, 32'd1);
    check("echo_first_word", {outputvalid, outputmessage[30:0]}, {1'b1, 31'h0000FFFC});
    wait_idle("echo_done");
    check("echo_reply_cycles", 32'(cyc - t0), 32'd5);
    check("echo_rx_count", 32'(cnt_rx - rx0), 32'd1);
    check("echo_out_count", 32'(cnt_out - out0), 32'd5);
    check("echo_type", {24'd0, typeoficmpout}, 32'h08);
    check("echo_code", {24'd0, codeout}, 32'h00);

    // Non-echo message with a correct checksum.
    rx0 = cnt_rx; out0 = cnt_out;
    send_msg(32'h0D00F2FF, 32'h0, 32'h0, 32'h0, 32'h0, -1, 0);
    step();
    check("nonecho_rxdone", {31'd0, rxdone}, 32'd1);
    check("nonecho_no_valid", {31'd0, outputvalid}, 32'd0);
    repeat (3) step();
    check("nonecho_type", {24'd0, typeoficmpout}, 32'h0D);
    check("nonecho_code", {24'd0, codeout}, 32'h00);
    check("nonecho_out_count", 32'(cnt_out - out0), 32'd0);

    // Corrupted checksum.
    rx0 = cnt_rx; err0 = cnt_err; out0 = cnt_out;
`ifdef ICMP_ECHO_CSUM_CHECK_EN
    send_msg(32'h0800F7FD, 32'h00010002, 32'h0, 32'h0, 32'h0, -1, 0);
    step();
    check("bad_csumerr", {31'd0, checksumerr}, 32'd1);
    check("bad_no_valid", {31'd0, outputvalid}, 32'd0);
    repeat (3) step();
    check("bad_err_count", 32'(cnt_err - err0), 32'd1);
    check("bad_rx_count", 32'(cnt_rx - rx0), 32'd0);
    check("bad_type_kept", {24'd0, typeoficmpout}, 32'h0D);
    check("bad_out_count", 32'(cnt_out - out0), 32'd0);
`else
    push5(32'h0000FFFC, 32'h00010002, 32'h0, 32'h0, 32'h0);
    send_msg(32'h0800F7FD, 32'h00010002, 32'h0, 32'h0, 32'h0, -1, 0);
    step();
    check("bad_rxdone", {31'd0, rxdone}, 32'd1);
    check("bad_csumerr_tied", {31'd0, checksumerr}, 32'd0);
    wait_idle("bad_done");
    check("bad_rx_count", 32'(cnt_rx - rx0), 32'd1);
    check("bad_err_count", 32'(cnt_err - err0), 32'd0);
    check("bad_type", {24'd0, typeoficmpout}, 32'h08);
    check("bad_out_count", 32'(cnt_out - out0), 32'd5);
`endif

    // End-around carry with a 2-cycle input gap after word 2.
    rx0 = cnt_rx; err0 = cnt_err;
    push5(32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 32'h0, 32'h0);
    send_msg(32'h0800F7FF, 32'h0000FFFF, 32'hFFFF0000, 32'h0, 32'h0, 2, 2);
    step();
    check("carry_rxdone", {31'd0, rxdone}, 32'd1);
    wait_idle("carry_done");
    check("carry_err_count", 32'(cnt_err - err0), 32'd0);

    // Backpressure on reply word 2 with ignored input pulses during SEND.
    rx0 = cnt_rx; out0 = cnt_out;
    push5(32'h00001DA3, 32'h00010002, 32'h12345678, 32'h9ABCDEF0, 32'h0);
    send_msg(32'h080015A3, 32'h00010002, 32'h12345678, 32'h9ABCDEF0, 32'h0, -1, 0);
    step();
    t0 = cyc;
    check("bp_first_word", outputmessage, 32'h00001DA3);
    step();
    step();
    outputready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inputdata  = 32'h0800F7FC;
      inputvalid = (i != 1);
      step();
      check("bp_hold_word2", outputmessage, 32'h12345678);
      check("bp_hold_valid", {31'd0, outputvalid}, 32'd1);
    end
    inputvalid  = 1'b0;
    outputready = 1'b1;
    wait_idle("bp_done");
    check("bp_reply_cycles", 32'(cyc - t0), 32'd8);
    repeat (4) step();
    check("bp_rx_count", 32'(cnt_rx - rx0), 32'd1);
    check("bp_out_count", 32'(cnt_out - out0), 32'd5);
    check("bp_idle_after", {31'd0, busy}, 32'd0);

    // Reset while reply word 3 is presented.
    push5(32'h0000FFFC, 32'h00010002, 32'h0, 32'h0, 32'h0);
    send_msg(32'h0800F7FC, 32'h00010002, 32'h0, 32'h0, 32'h0, -1, 0);
    repeat (4) step();
    check("rst_mid_pending", 32'(exp_q.size()), 32'd2);
    hardreset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_valid", {31'd0, outputvalid}, 32'd0);
    check("rst_mid_message", outputmessage, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_type", {16'd0, typeoficmpout, codeout}, 32'h0);
    #8 hardreset_n = 1'b1;
    step();
    rx0 = cnt_rx; out0 = cnt_out;
    push5(32'h0000FFFC, 32'h00010002, 32'h0, 32'h0, 32'h0);
    send_msg(32'h0800F7FC, 32'h00010002, 32'h0, 32'h0, 32'h0, -1, 0);
    step();
    check("after_rst_rxdone", {31'd0, rxdone}, 32'd1);
    wait_idle("after_rst_done");
    check("after_rst_out_count", 32'(cnt_out - out0), 32'd5);
    check("after_rst_type", {24'd0, typeoficmpout}, 32'h08);

    repeat (3) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
